// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data memory, with owner-tagged
// read responses, per-port hold registers and a contention counter. Define MEM_ARB_RR_EN for round-robin conflicts.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_stall,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [31:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } own_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  own_t              own_p1, own_nxt;
  logic              both_p0;
  logic              dm_pri;
  logic [DATA_W-1:0] if_hold_p1, dm_hold_p1;

  assign both_p0 = if_req & dm_req & ~rst;

`ifdef MEM_ARB_RR_EN
  // last_dm_p1 = 1 when DM won the most recent conflict; the other port wins the next one
  logic last_dm_p1;
  assign dm_pri = ~last_dm_p1;

  always_ff @(posedge clk) begin
    if (rst)
      last_dm_p1 <= 1'b0;
    else if (both_p0)
      last_dm_p1 <= dm_gnt;
  end
`else
  assign dm_pri = 1'b1;
`endif

  // ---- p0: grant and SRAM drive ----
  assign dm_gnt   = ~rst & dm_req & (~if_req | dm_pri);
  assign if_gnt   = ~rst & if_req & (~dm_req | ~dm_pri);
  assign if_stall = if_req & ~if_gnt;
  assign dm_stall = dm_req & ~dm_gnt;

  assign sram_en    = if_gnt | dm_gnt;
  assign sram_wen   = dm_gnt ? dm_wen : 4'd0;
  assign sram_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
  assign sram_wdata = dm_gnt ? dm_wdata : '0;

  always_comb begin
    own_nxt = OWN_NONE;
    if (if_gnt)
      own_nxt = OWN_IF;
    else if (dm_gnt && (dm_wen == 4'd0))
      own_nxt = OWN_DM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_p1       <= OWN_NONE;
      conflict_cnt <= 32'd0;
    end else begin
      own_p1 <= own_nxt;
      if (both_p0)
        conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  // ---- p1: response steering and hold ----
  assign if_rvalid = ~rst & (own_p1 == OWN_IF);
  assign dm_rvalid = ~rst & (own_p1 == OWN_DM);
  assign if_rdata  = if_rvalid ? sram_rdata : if_hold_p1;
  assign dm_rdata  = dm_rvalid ? sram_rdata : dm_hold_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_hold_p1 <= '0;
      dm_hold_p1 <= '0;
    end else begin
      if (if_rvalid)
        if_hold_p1 <= sram_rdata;
      if (dm_rvalid)
        dm_hold_p1 <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs are checked 1 time unit later.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, dm_req;
  logic [ADDR_W-1:0] if_addr, dm_addr;
  logic [3:0]        dm_wen;
  logic [DATA_W-1:0] dm_wdata, sram_rdata;
  logic              if_gnt, if_stall, if_rvalid;
  logic              dm_gnt, dm_stall, dm_rvalid;
  logic [DATA_W-1:0] if_rdata, dm_rdata, sram_wdata;
  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit rr_en;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_stall(dm_stall), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    rst = 1'b1; if_req = 1'b1; if_addr = '0; dm_req = 1'b0; dm_addr = '0;
    dm_wen = 4'd0; dm_wdata = '0; sram_rdata = '0;

    // reset state, with a fetch request pending
    cyc(); #1;
    check_val("rst_if_gnt",   32'(if_gnt), 32'd0);
    check_val("rst_if_stall", 32'(if_stall), 32'd1);
    check_val("rst_sram_en",  32'(sram_en), 32'd0);
    check_val("rst_rvalid",   32'({if_rvalid, dm_rvalid}), 32'd0);
    check_val("rst_cnt",      conflict_cnt, 32'd0);
    check_val("rst_if_rdata", if_rdata, 32'd0);
    check_val("rst_dm_rdata", dm_rdata, 32'd0);
    cyc(); rst = 1'b0; if_req = 1'b0;

    // single fetch
    cyc(); if_req = 1'b1; if_addr = 32'h100; #1;
    check_val("f_if_gnt",    32'(if_gnt), 32'd1);
    check_val("f_sram_en",   32'(sram_en), 32'd1);
    check_val("f_sram_addr", sram_addr, 32'h100);
    check_val("f_sram_wen",  32'(sram_wen), 32'd0);
    cyc(); if_req = 1'b0; sram_rdata = 32'hDEADBEEF; #1;
    check_val("f_if_rvalid", 32'(if_rvalid), 32'd1);
    check_val("f_if_rdata",  if_rdata, 32'hDEADBEEF);
    check_val("f_dm_rvalid", 32'(dm_rvalid), 32'd0);
    cyc(); sram_rdata = 32'h55555555; #1;
    check_val("f_if_rvalid_off", 32'(if_rvalid), 32'd0);
    check_val("f_if_hold",       if_rdata, 32'hDEADBEEF);

    // data write
    cyc(); dm_req = 1'b1; dm_wen = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'h1234; #1;
    check_val("w_dm_gnt",     32'(dm_gnt), 32'd1);
    check_val("w_sram_wen",   32'(sram_wen), 32'b0011);
    check_val("w_sram_addr",  sram_addr, 32'h200);
    check_val("w_sram_wdata", sram_wdata, 32'h1234);
    cyc(); dm_req = 1'b0; dm_wen = 4'd0; dm_wdata = '0; #1;
    check_val("w_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_val("w_idle_en",   32'(sram_en), 32'd0);
    check_val("w_idle_addr", sram_addr, 32'd0);
    check_val("w_dm_rdata",  dm_rdata, 32'd0);

    // first conflict: DM wins in both configurations
    cyc(); if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_addr = 32'h400; #1;
    check_val("c_dm_gnt",    32'(dm_gnt), 32'd1);
    check_val("c_if_gnt",    32'(if_gnt), 32'd0);
    check_val("c_if_stall",  32'(if_stall), 32'd1);
    check_val("c_dm_stall",  32'(dm_stall), 32'd0);
    check_val("c_sram_addr", sram_addr, 32'h400);
    cyc(); dm_req = 1'b0; sram_rdata = 32'hA5A5A5A5; #1;
    check_val("c_if_gnt2",    32'(if_gnt), 32'd1);
    check_val("c_sram_addr2", sram_addr, 32'h300);
    check_val("c_dm_rvalid",  32'(dm_rvalid), 32'd1);
    check_val("c_if_rvalid",  32'(if_rvalid), 32'd0);
    check_val("c_dm_rdata",   dm_rdata, 32'hA5A5A5A5);
    check_val("c_cnt",        conflict_cnt, 32'd1);
    cyc(); if_req = 1'b0; sram_rdata = 32'h11112222; #1;
    check_val("c_if_rvalid2", 32'(if_rvalid), 32'd1);
    check_val("c_if_rdata",   if_rdata, 32'h11112222);
    check_val("c_dm_hold",    dm_rdata, 32'hA5A5A5A5);

    // back-to-back reads, no cross-tagging
    cyc(); if_req = 1'b1; if_addr = 32'h10; #1;
    check_val("b_if_gnt", 32'(if_gnt), 32'd1);
    cyc(); if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h20; sram_rdata = 32'hAAAA0001; #1;
    check_val("b_dm_gnt",    32'(dm_gnt), 32'd1);
    check_val("b_if_rvalid", 32'(if_rvalid), 32'd1);
    check_val("b_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check_val("b_if_rdata",  if_rdata, 32'hAAAA0001);
    cyc(); dm_req = 1'b0; sram_rdata = 32'hBBBB0002; #1;
    check_val("b_dm_rvalid2", 32'(dm_rvalid), 32'd1);
    check_val("b_if_rvalid2", 32'(if_rvalid), 32'd0);
    check_val("b_dm_rdata",   dm_rdata, 32'hBBBB0002);
    check_val("b_if_hold",    if_rdata, 32'hAAAA0001);

    // reset mid-read
    cyc(); if_req = 1'b1; if_addr = 32'h40; #1;
    check_val("r_if_gnt", 32'(if_gnt), 32'd1);
    cyc(); if_req = 1'b0; rst = 1'b1; sram_rdata = 32'hCCCCCCCC; #1;
    check_val("r_if_rvalid", 32'(if_rvalid), 32'd0);
    check_val("r_sram_en",   32'(sram_en), 32'd0);
    cyc(); rst = 1'b0; #1;
    check_val("r_if_hold", if_rdata, 32'd0);
    check_val("r_dm_hold", dm_rdata, 32'd0);
    check_val("r_cnt",     conflict_cnt, 32'd0);

    // four consecutive conflicts from reset
    for (int i = 0; i < 4; i++) begin
      cyc(); if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h500; dm_addr = 32'h600; #1;
      check_val($sformatf("k%0d_dm_gnt", i), 32'(dm_gnt), rr_en ? 32'((i % 2) == 0) : 32'd1);
      check_val($sformatf("k%0d_if_gnt", i), 32'(if_gnt), rr_en ? 32'((i % 2) == 1) : 32'd0);
    end
    cyc(); if_req = 1'b0; dm_req = 1'b0; #1;
    check_val("k_cnt", conflict_cnt, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
